multi_channel_pid_controller: RTL and testbench

MULTI_CHANNEL_PID_CONTROLLER -- requirements
Module: multi_channel_pid_controller

---
 rtl/msj_pid_pkg.sv | 40 ++++
 rtl/pid_clamp.sv | 35 +++
 rtl/multi_channel_pid_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multi_channel_pid_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msj_pid_pkg.sv
// ----------------------------------------------------------------------------
// msj_pid_pkg
// Shared definitions for the multi-channel PID controller: controller mode
// encoding, configuration field indices and the sweep FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package msj_pid_pkg;

    // Per-channel controller mode, held in the low two bits of cfg field 10.
    typedef enum logic [1:0] {
        MODE_POSITION    = 2'd0,  // err = sp - position
        MODE_VELOCITY    = 2'd1,  // err = sp - velocity
        MODE_PASSTHROUGH = 2'd2,  // duty = sp, clamped to the output limits
        MODE_ZERO        = 2'd3   // duty = zero_speed, loop state frozen
    } pid_mode_e;

    // Configuration field indices (cfg_addr).
    localparam logic [3:0] CFG_KP       = 4'd0;
    localparam logic [3:0] CFG_KI       = 4'd1;
    localparam logic [3:0] CFG_KD       = 4'd2;
    localparam logic [3:0] CFG_OUT_POS  = 4'd3;
    localparam logic [3:0] CFG_OUT_NEG  = 4'd4;
    localparam logic [3:0] CFG_INT_POS  = 4'd5;
    localparam logic [3:0] CFG_INT_NEG  = 4'd6;
    localparam logic [3:0] CFG_DEADBAND = 4'd7;
    localparam logic [3:0] CFG_ZERO     = 4'd8;
    localparam logic [3:0] CFG_DIVIDER  = 4'd9;
    localparam logic [3:0] CFG_MODE     = 4'd10;

    // Sweep FSM: ERR..OUT repeat once per channel, then DONE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL   = 3'd2,
        ST_INTEG = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } pid_state_e;

endpackage

// File: rtl/pid_clamp.sv
// ----------------------------------------------------------------------------
// pid_clamp
// Signed saturation of a wide value into a narrower range [lo, hi].
// Ports:
//   value  - signed IN_W-bit input
//   lo, hi - signed OUT_W-bit limits (sign-extended for the comparison)
//   result - signed OUT_W-bit saturated value
// ----------------------------------------------------------------------------
module pid_clamp #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic signed [OUT_W-1:0] lo,
    input  logic signed [OUT_W-1:0] hi,
    output logic signed [OUT_W-1:0] result
);

    logic signed [IN_W-1:0] lo_ext;
    logic signed [IN_W-1:0] hi_ext;

    assign lo_ext = IN_W'(lo);
    assign hi_ext = IN_W'(hi);

    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = value[OUT_W-1:0];
        if (value > hi_ext) begin
            result = hi;
        end else if (value < lo_ext) begin
            result = lo;
        end
    end

endmodule

// File: rtl/multi_channel_pid_controller.sv
// ----------------------------------------------------------------------------
// multi_channel_pid_controller
// Time-multiplexed PID controller: one shared datapath sweeps channels
// 0..NUM_CH-1, four cycles per channel (ERR, MUL, INTEG, OUT), on each rising
// edge of update_controller.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   cfg_we/ch/addr/data   - per-channel configuration write
//   sp, position, velocity- per-channel setpoint and measurements
//   integral_clear        - per-channel integral zeroing request
//   update_controller     - rising edge starts a sweep
//   duty                  - per-channel controller output
//   busy, done, overrun   - sweep active, sweep-end pulse, sticky overrun
// ----------------------------------------------------------------------------
module multi_channel_pid_controller
    import msj_pid_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [3:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    input  logic signed [DATA_W-1:0] sp       [NUM_CH],
    input  logic signed [DATA_W-1:0] position [NUM_CH],
    input  logic signed [DATA_W-1:0] velocity [NUM_CH],
    input  logic [NUM_CH-1:0]        integral_clear,
    input  logic                     update_controller,
    output logic signed [DATA_W-1:0] duty     [NUM_CH],
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int PROD_W = 2 * DATA_W;   // gain * error products
    localparam int ISUM_W = PROD_W + 1;   // integral + Ki*err
    localparam int SUM_W  = PROD_W + 2;   // pterm + dterm + integral
    localparam int OSUM_W = SUM_W + 1;    // shifted sum + zero_speed
    localparam int SH_W   = $clog2(DATA_W);

    // Per-channel configuration and loop state.
    logic signed [DATA_W-1:0] kp_q [NUM_CH], ki_q [NUM_CH], kd_q [NUM_CH];
    logic signed [DATA_W-1:0] out_pos_q [NUM_CH], out_neg_q [NUM_CH];
    logic signed [DATA_W-1:0] int_pos_q [NUM_CH], int_neg_q [NUM_CH];
    logic signed [DATA_W-1:0] dead_q [NUM_CH], zero_q [NUM_CH], div_q [NUM_CH];
    pid_mode_e                mode_q [NUM_CH];
    logic signed [DATA_W-1:0] integral_q [NUM_CH];
    logic signed [DATA_W-1:0] last_err_q [NUM_CH];

    // Sequencing.
    pid_state_e      state_q, state_d;
    logic [CH_W-1:0] ch_q;
    logic            update_prev_q;
    logic            update_edge;
    logic            last_ch;

    // Working copy of the channel being processed, latched in ERR.
    logic signed [DATA_W-1:0] cur_kp, cur_ki, cur_kd, cur_out_pos, cur_out_neg;
    logic signed [DATA_W-1:0] cur_int_pos, cur_int_neg, cur_dead, cur_zero, cur_div;
    logic signed [DATA_W-1:0] cur_sp, cur_err, cur_last;
    pid_mode_e                cur_mode;
    logic signed [PROD_W-1:0] pterm_q, iterm_q, dterm_q;

    // Combinational datapath.
    logic signed [DATA_W-1:0] err_delta;
    logic signed [DATA_W:0]   err_ext, abs_err;
    logic                     in_dead, pid_loop, pterm_in_range, accumulate;
    logic signed [ISUM_W-1:0] int_sum;
    logic signed [DATA_W-1:0] int_clamped;
    logic signed [SUM_W-1:0]  pid_sum, pid_shifted;
    logic [SH_W-1:0]          shamt;
    logic signed [OSUM_W-1:0] out_pre;
    logic signed [DATA_W-1:0] out_clamped;

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: these are flop arrays, not RAM, so clearing every entry on reset is legal and cheap to reason about.
            for (int k = 0; k < NUM_CH; k++) begin
                kp_q[k]      <= '0;
                ki_q[k]      <= '0;
                kd_q[k]      <= '0;
                out_pos_q[k] <= '0;
                out_neg_q[k] <= '0;
                int_pos_q[k] <= '0;
                int_neg_q[k] <= '0;
                dead_q[k]    <= '0;
                zero_q[k]    <= '0;
                div_q[k]     <= '0;
                mode_q[k]    <= MODE_POSITION;
            end
        end else if (cfg_we) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (cfg_addr)
                CFG_KP:       kp_q[cfg_ch]      <= cfg_data;
                CFG_KI:       ki_q[cfg_ch]      <= cfg_data;
                CFG_KD:       kd_q[cfg_ch]      <= cfg_data;
                CFG_OUT_POS:  out_pos_q[cfg_ch] <= cfg_data;
                CFG_OUT_NEG:  out_neg_q[cfg_ch] <= cfg_data;
                CFG_INT_POS:  int_pos_q[cfg_ch] <= cfg_data;
                CFG_INT_NEG:  int_neg_q[cfg_ch] <= cfg_data;
                CFG_DEADBAND: dead_q[cfg_ch]    <= cfg_data;
                CFG_ZERO:     zero_q[cfg_ch]    <= cfg_data;
                CFG_DIVIDER:  div_q[cfg_ch]     <= cfg_data;
                CFG_MODE:     mode_q[cfg_ch]    <= pid_mode_e'(cfg_data[1:0]);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------------
    assign update_edge = update_controller && !update_prev_q;
    assign last_ch     = (ch_q == CH_W'(NUM_CH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (update_edge) state_d = ST_ERR;
            ST_ERR:   state_d = ST_MUL;
            ST_MUL:   state_d = ST_INTEG;
            ST_INTEG: state_d = ST_OUT;
            ST_OUT:   state_d = last_ch ? ST_DONE : ST_ERR;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Channel counter and status flags. busy and done are registered, so done
    // rises on the edge that leaves DONE, one cycle after the last OUT write.
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_q          <= '0;
            update_prev_q <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            update_prev_q <= update_controller;
            busy          <= (state_d != ST_IDLE);
            done          <= (state_q == ST_DONE);
            if (update_edge && state_q != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (state_q == ST_IDLE) begin
                ch_q <= '0;
            end else if (state_q == ST_OUT && !last_ch) begin
                ch_q <= ch_q + CH_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath pipeline: ERR latches the channel, MUL forms the products.
    // These registers are only consumed later in the same sweep, so they
    // carry no reset.
    // ------------------------------------------------------------------------
    assign err_delta = cur_err - cur_last;

    always_ff @(posedge clock) begin
        if (state_q == ST_ERR) begin
            cur_kp      <= kp_q[ch_q];
            cur_ki      <= ki_q[ch_q];
            cur_kd      <= kd_q[ch_q];
            cur_out_pos <= out_pos_q[ch_q];
            cur_out_neg <= out_neg_q[ch_q];
            cur_int_pos <= int_pos_q[ch_q];
            cur_int_neg <= int_neg_q[ch_q];
            cur_dead    <= dead_q[ch_q];
            cur_zero    <= zero_q[ch_q];
            cur_div     <= div_q[ch_q];
            cur_mode    <= mode_q[ch_q];
            cur_sp      <= sp[ch_q];
            cur_err     <= sp[ch_q] - ((mode_q[ch_q] == MODE_VELOCITY) ? velocity[ch_q]
                                                                       : position[ch_q]);
            cur_last    <= last_err_q[ch_q];
        end
        if (state_q == ST_MUL) begin
            pterm_q <= PROD_W'(cur_kp) * PROD_W'(cur_err);
            iterm_q <= PROD_W'(cur_ki) * PROD_W'(cur_err);
            dterm_q <= PROD_W'(cur_kd) * PROD_W'(err_delta);
        end
    end

    // Dead-band and anti-windup decisions (error widened so |err| cannot wrap).
    assign err_ext        = (DATA_W + 1)'(cur_err);
    assign abs_err        = (err_ext < 0) ? -err_ext : err_ext;
    assign in_dead        = abs_err < (DATA_W + 1)'(cur_dead);
    assign pid_loop       = (cur_mode == MODE_POSITION) || (cur_mode == MODE_VELOCITY);
    assign pterm_in_range = (pterm_q > PROD_W'(cur_out_neg)) && (pterm_q < PROD_W'(cur_out_pos));
    assign accumulate     = pid_loop && !in_dead && pterm_in_range;

    assign int_sum = ISUM_W'(integral_q[ch_q]) + ISUM_W'(iterm_q);

    pid_clamp #(.IN_W(ISUM_W), .OUT_W(DATA_W)) u_int_clamp (
        .value  (int_sum),
        .lo     (cur_int_neg),
        .hi     (cur_int_pos),
        .result (int_clamped)
    );

    // integral_clear wins over accumulation and acts whether or not a sweep runs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) integral_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (integral_clear[k]) begin
                    integral_q[k] <= '0;
                end else if (state_q == ST_INTEG && ch_q == CH_W'(k) && accumulate) begin
                    integral_q[k] <= int_clamped;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage. In OUT the integral array already holds this sweep's value.
    // ------------------------------------------------------------------------
    assign pid_sum     = SUM_W'(pterm_q) + SUM_W'(dterm_q) + SUM_W'(integral_q[ch_q]);
    assign shamt       = ($unsigned(cur_div) >= DATA_W'(DATA_W - 1)) ? SH_W'(DATA_W - 1)
                                                                     : cur_div[SH_W-1:0];
    assign pid_shifted = pid_sum >>> shamt;
    assign out_pre     = (cur_mode == MODE_PASSTHROUGH) ? OSUM_W'(cur_sp)
                                                        : OSUM_W'(pid_shifted) + OSUM_W'(cur_zero);

    pid_clamp #(.IN_W(OSUM_W), .OUT_W(DATA_W)) u_out_clamp (
        .value  (out_pre),
        .lo     (cur_out_neg),
        .hi     (cur_out_pos),
        .result (out_clamped)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                duty[k]       <= '0;
                last_err_q[k] <= '0;
            end
        end else if (state_q == ST_OUT) begin
            case (cur_mode)
                MODE_ZERO:        duty[ch_q] <= cur_zero;
                MODE_PASSTHROUGH: duty[ch_q] <= out_clamped;
                default: begin
                    duty[ch_q]       <= in_dead ? cur_zero : out_clamped;
                    last_err_q[ch_q] <= cur_err;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_pid_controller.sv
// ----------------------------------------------------------------------------
// tb_multi_channel_pid_controller
// Directed bench for multi_channel_pid_controller (NUM_CH=4, DATA_W=32) with
// hand-computed expected values for each sweep.
// ----------------------------------------------------------------------------
module tb_multi_channel_pid_controller;
    import msj_pid_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DONE_AT = 4 * NUM_CH + 1;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     cfg_we;
    logic [1:0]               cfg_ch;
    logic [3:0]               cfg_addr;
    logic signed [DATA_W-1:0] cfg_data;
    logic signed [DATA_W-1:0] sp       [NUM_CH];
    logic signed [DATA_W-1:0] position [NUM_CH];
    logic signed [DATA_W-1:0] velocity [NUM_CH];
    logic [NUM_CH-1:0]        integral_clear;
    logic                     update_controller;
    logic signed [DATA_W-1:0] duty     [NUM_CH];
    logic                     busy, done, overrun;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    multi_channel_pid_controller #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .cfg_we            (cfg_we),
        .cfg_ch            (cfg_ch),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .sp                (sp),
        .position          (position),
        .velocity          (velocity),
        .integral_clear    (integral_clear),
        .update_controller (update_controller),
        .duty              (duty),
        .busy              (busy),
        .done              (done),
        .overrun           (overrun)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        cfg_we            = 1'b0;
        cfg_ch            = '0;
        cfg_addr          = '0;
        cfg_data          = '0;
        integral_clear    = '0;
        update_controller = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sp[k] = 0; position[k] = 0; velocity[k] = 0;
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input logic [3:0] addr, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_ch(input int ch, input int kp, input int ki, input int kd,
                          input int opos, input int oneg, input int ipos, input int ineg,
                          input int dead, input int zero, input int div, input int mode);
        cfg_write(ch, CFG_KP, kp);
        cfg_write(ch, CFG_KI, ki);
        cfg_write(ch, CFG_KD, kd);
        cfg_write(ch, CFG_OUT_POS, opos);
        cfg_write(ch, CFG_OUT_NEG, oneg);
        cfg_write(ch, CFG_INT_POS, ipos);
        cfg_write(ch, CFG_INT_NEG, ineg);
        cfg_write(ch, CFG_DEADBAND, dead);
        cfg_write(ch, CFG_ZERO, zero);
        cfg_write(ch, CFG_DIVIDER, div);
        cfg_write(ch, CFG_MODE, mode);
    endtask

    task automatic drive_kp0(input int kp_val);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_addr = CFG_KP;
        cfg_data = kp_val;
    endtask

    // One sweep. cfg_cycle: -1 none, 0 = ch0 Kp write alongside the update
    // edge, 1 = ch0 Kp write landing at the end of ch0's ERR cycle.
    task automatic sweep(input string tag, input int cfg_cycle, input int kp_val);
        int cyc;
        update_controller = 1'b1;
        if (cfg_cycle == 0) drive_kp0(kp_val);
        tick();
        update_controller = 1'b0;
        cfg_we = 1'b0;
        cyc = 0;
        if (cfg_cycle == 1) begin
            drive_kp0(kp_val);
            tick();
            cfg_we = 1'b0;
            cyc = 1;
        end
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_done_at"}, cyc, DONE_AT);
    endtask

    initial begin
        int cyc;
        int done_seen;

        // ---------------- reset state ----------------
        do_reset();
        for (int k = 0; k < NUM_CH; k++) check($sformatf("rst_duty%0d", k), duty[k], 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);

        // ---------------- basic P, exact latency ----------------
        set_ch(0, 2, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, 0);
        set_ch(1, 1, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, 0);
        sp[0] = 100; position[0] = 40;
        sp[1] = 50;
        update_controller = 1'b1;
        tick();
        update_controller = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1)  check("lat_busy_c1", busy, 1);
            if (c == 3)  check("lat_duty0_c3", duty[0], 0);
            if (c == 4)  check("lat_duty0_c4", duty[0], 120);
            if (c == 7)  check("lat_duty1_c7", duty[1], 0);
            if (c == 8)  check("lat_duty1_c8", duty[1], 50);
            if (c == 16) check("lat_done_c16", done, 0);
            if (c == 17) check("lat_done_c17", done, 1);
            if (c == 18) begin
                check("lat_done_c18", done, 0);
                check("lat_busy_c18", busy, 0);
            end
        end

        // cfg write during ch0 ERR only applies next sweep: 2*60 then 5*60
        sweep("cfg_in_err", 1, 5);
        check("cfg_in_err_duty0", duty[0], 120);
        check("cfg_in_err_duty1", duty[1], 50);
        sweep("cfg_next", -1, 0);
        check("cfg_next_duty0", duty[0], 300);
        // cfg write in the same cycle as the edge: applied and sweep runs, 3*60
        sweep("cfg_with_edge", 0, 3);
        check("cfg_with_edge_duty0", duty[0], 180);

        // ---------------- velocity mode, divider, clamps ----------------
        do_reset();
        set_ch(0, 1, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, int'(MODE_VELOCITY));
        set_ch(1, 10, 0, 0, 1000, -1000, 0, 0, 0, 0, 2, 0);
        set_ch(2, 100, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, 0);
        set_ch(3, 1, 0, 0, 1000, -1000, 0, 0, 0, 5, 40, 0);
        sp[0] = 100; position[0] = 90; velocity[0] = 30;  // err 70
        sp[1] = 0;   position[1] = 50;                    // -500 >>> 2
        sp[2] = 0;   position[2] = 50;                    // -5000 -> -1000
        sp[3] = 100;                                      // 100 >>> 31 = 0, +5
        sweep("mix", -1, 0);
        check("vel_duty0", duty[0], 70);
        check("div_duty1", duty[1], -125);
        check("negclamp_duty2", duty[2], -1000);
        check("divsat_duty3", duty[3], 5);

        // ---------------- dead-band, Kd, modes 2 and 3 ----------------
        do_reset();
        set_ch(0, 0, 1, 0, 1000, -1000, 1000, -1000, 10, 7, 0, 0);
        set_ch(1, 0, 0, 3, 1000, -1000, 0, 0, 0, 0, 0, 0);
        set_ch(2, 0, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, int'(MODE_PASSTHROUGH));
        set_ch(3, 5, 0, 0, 1000, -1000, 0, 0, 0, -7, 0, int'(MODE_ZERO));
        sp[0] = 5; sp[1] = 10; sp[2] = 1500; sp[3] = 100;
        sweep("db1", -1, 0);
        check("db_duty0", duty[0], 7);
        check("kd1_duty1", duty[1], 30);
        check("m2_hi_duty2", duty[2], 1000);
        check("m3_duty3", duty[3], -7);
        sp[0] = 20; sp[1] = 4; sp[2] = -300;
        sweep("db2", -1, 0);
        check("db_hold_duty0", duty[0], 27);   // 7 + 20: integral held at 0 in dead band
        check("kd2_duty1", duty[1], -18);      // 3 * (4 - 10)
        check("m2_mid_duty2", duty[2], -300);
        check("m3_again_duty3", duty[3], -7);

        // ---------------- anti-windup and integral clamp ----------------
        do_reset();
        set_ch(0, 100, 1, 0, 1000, -1000, 5000, -5000, 0, 0, 0, 0);
        set_ch(1, 0, 10, 0, 5000, -5000, 1200, -1200, 0, 0, 0, 0);
        sp[0] = 20; sp[1] = 50;
        sweep("aw1", -1, 0);
        check("aw1_duty0", duty[0], 1000);
        check("int1_duty1", duty[1], 500);
        sweep("aw2", -1, 0);
        check("aw2_duty0", duty[0], 1000);
        check("int2_duty1", duty[1], 1000);
        sweep("aw3", -1, 0);
        check("aw3_duty0", duty[0], 1000);
        check("int3_duty1", duty[1], 1200);
        cfg_write(0, CFG_KP, 0);
        sweep("aw4", -1, 0);
        check("aw_int_zero_duty0", duty[0], 20);  // integral was still 0
        check("int4_duty1", duty[1], 1200);
        integral_clear = 4'b0010;
        tick();
        integral_clear = '0;
        sweep("clr_idle", -1, 0);
        check("clr_idle_duty1", duty[1], 500);
        check("clr_idle_duty0", duty[0], 40);
        integral_clear = 4'b0010;
        sweep("clr_held", -1, 0);
        integral_clear = '0;
        check("clr_prio_duty1", duty[1], 0);
        check("clr_other_duty0", duty[0], 60);

        // ---------------- overrun ----------------
        do_reset();
        set_ch(0, 2, 0, 0, 1000, -1000, 0, 0, 0, 0, 0, 0);
        sp[0] = 100; position[0] = 40;
        update_controller = 1'b1;
        tick();                     // cycle 0
        update_controller = 1'b0;
        tick();
        tick();                     // cycle 2
        check("ovr_before", overrun, 0);
        update_controller = 1'b1;
        tick();                     // cycle 3: edge while busy
        update_controller = 1'b0;
        check("ovr_set", overrun, 1);
        check("ovr_busy", busy, 1);
        cyc = 3;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("ovr_done_at", cyc, DONE_AT);
        check("ovr_duty0", duty[0], 120);
        sweep("ovr_sticky", -1, 0);
        check("ovr_sticky", overrun, 1);

        // ---------------- reset mid-sweep ----------------
        update_controller = 1'b1;
        tick();                     // cycle 0
        update_controller = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        reset = 1'b1;
        tick();                     // reset sampled at edge 6
        reset = 1'b0;
        for (int k = 0; k < NUM_CH; k++) check($sformatf("midrst_duty%0d", k), duty[k], 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("midrst_no_done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
